// File: rtl/spi_stream_buffer.sv
// spi_stream_buffer: SPI mode-0 secondary that deserialises WORD_W-bit words
// into a DEPTH-entry FIFO, drained to a parallel port by a watermark-hysteresis
// engine at a programmable pace (one pop every out_div+1 cycles).
// Optional feature: define SPI_STATUS_EN to shift a status word out on miso
// ({overflow, draining, fill_level}); otherwise miso is tied low.
module spi_stream_buffer #(
  parameter int WORD_W  = 8,
  parameter int DEPTH   = 16,
  parameter int HIGH_WM = 16,
  parameter int LOW_WM  = 0,
  parameter int DIV_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sck,
  input  logic                     cs_n,
  input  logic                     mosi,
  output logic                     miso,
  input  logic [DIV_W-1:0]         out_div,
  output logic [WORD_W-1:0]        out_data,
  output logic                     out_strobe,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     draining,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int CW = $clog2(WORD_W + 1);
`ifdef SPI_STATUS_EN
  localparam int CS_SYNC_N = 3;
`else
  localparam int CS_SYNC_N = 2;
`endif

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  logic [2:0]           sck_sync_r;
  logic [CS_SYNC_N-1:0] cs_sync_r;
  logic [1:0]           mosi_sync_r;
  logic                 sck_rise_s;
  logic                 cs_low_s;

  logic [CW-1:0]        bit_cnt_r;
  logic [WORD_W-2:0]    shift_r;
  logic [WORD_W-1:0]    rx_word_s;
  logic                 wr_req_s;

  logic [WORD_W-1:0]    mem_r [DEPTH];
  logic [AW-1:0]        wptr_r, rptr_r;
  logic [FW-1:0]        count_r, count_nxt_s;
  logic                 pop_s, wr_ok_s;

  state_t               state_r, state_nxt_s;
  logic [DIV_W-1:0]     div_cnt_r, div_cnt_nxt_s;
  logic [DIV_W-1:0]     div_lim_r, div_lim_nxt_s;
  logic [WORD_W-1:0]    out_data_r;
  logic                 out_strobe_r;
  logic                 overflow_r;

  assign sck_rise_s = sck_sync_r[1] & ~sck_sync_r[2];
  assign cs_low_s   = ~cs_sync_r[1];

  // Two-flop synchronisers for the asynchronous SPI pins plus one history stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_r  <= 3'b000;
      cs_sync_r   <= {CS_SYNC_N{1'b1}};
      mosi_sync_r <= 2'b00;
    end else begin
      sck_sync_r  <= {sck_sync_r[1:0], sck};
      cs_sync_r   <= {cs_sync_r[CS_SYNC_N-2:0], cs_n};
      mosi_sync_r <= {mosi_sync_r[0], mosi};
    end
  end

  // Assembled word and write request: the request fires in the cycle the last bit is shifted.
  always_comb begin
    rx_word_s = {shift_r, mosi_sync_r[1]};
    wr_req_s  = cs_low_s && sck_rise_s && (bit_cnt_r == CW'(WORD_W - 1));
  end

  // MSB-first receive shifter; chip select high discards any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_r <= {CW{1'b0}};
      shift_r   <= {(WORD_W-1){1'b0}};
    end else if (!cs_low_s) begin
      bit_cnt_r <= {CW{1'b0}};
    end else if (sck_rise_s) begin
      shift_r   <= rx_word_s[WORD_W-2:0];
      bit_cnt_r <= wr_req_s ? {CW{1'b0}} : bit_cnt_r + CW'(1);
    end
  end

  // Pop/accept decisions; a pop in the same cycle frees a slot for a write into a full FIFO.
  always_comb begin
    pop_s   = (state_r == DRAIN) && (count_r != {FW{1'b0}}) && (div_cnt_r == div_lim_r);
    wr_ok_s = wr_req_s && ((count_r != FW'(DEPTH)) || pop_s);
    count_nxt_s = count_r;
    if (wr_ok_s && !pop_s) begin
      count_nxt_s = count_r + FW'(1);
    end else if (pop_s && !wr_ok_s) begin
      count_nxt_s = count_r - FW'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Drain state and pacing divider; the limit is sampled from out_div only at reload points.
  always_comb begin
    state_nxt_s   = state_r;
    div_cnt_nxt_s = div_cnt_r;
    div_lim_nxt_s = div_lim_r;
    case (state_r)
      IDLE: begin
        div_cnt_nxt_s = {DIV_W{1'b0}};
        div_lim_nxt_s = out_div;
        if (count_r >= FW'(HIGH_WM)) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRAIN: begin
        if (pop_s) begin
          div_cnt_nxt_s = {DIV_W{1'b0}};
          div_lim_nxt_s = out_div;
        end else if (count_r != {FW{1'b0}}) begin
          div_cnt_nxt_s = div_cnt_r + DIV_W'(1);
        end else begin
          div_cnt_nxt_s = div_cnt_r;
        end
        if (count_nxt_s <= FW'(LOW_WM)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        div_cnt_nxt_s = {DIV_W{1'b0}};
        div_lim_nxt_s = out_div;
      end
    endcase
  end

  // FIFO storage; contents are not reset, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wptr_r] <= rx_word_s;
    end
  end

  // Pointers, occupancy, drain state, registered output word/strobe and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r       <= {AW{1'b0}};
      rptr_r       <= {AW{1'b0}};
      count_r      <= {FW{1'b0}};
      state_r      <= IDLE;
      div_cnt_r    <= {DIV_W{1'b0}};
      div_lim_r    <= {DIV_W{1'b0}};
      out_data_r   <= {WORD_W{1'b0}};
      out_strobe_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      if (wr_ok_s) wptr_r <= wptr_r + AW'(1);
      if (pop_s) begin
        rptr_r     <= rptr_r + AW'(1);
        out_data_r <= mem_r[rptr_r];
      end
      count_r      <= count_nxt_s;
      state_r      <= state_nxt_s;
      div_cnt_r    <= div_cnt_nxt_s;
      div_lim_r    <= div_lim_nxt_s;
      out_strobe_r <= pop_s;
      overflow_r   <= overflow_r | (wr_req_s & ~wr_ok_s);
    end
  end

  assign out_data   = out_data_r;
  assign out_strobe = out_strobe_r;
  assign fill_level = count_r;
  assign draining   = (state_r == DRAIN);
  assign overflow   = overflow_r;

`ifdef SPI_STATUS_EN
  logic                 sck_fall_s;
  logic                 cs_fall_s;
  logic [WORD_W-3:0]    lvl_s;
  logic [WORD_W-1:0]    tx_r, tx_nxt_s;
  logic                 miso_r;

  assign sck_fall_s = ~sck_sync_r[1] & sck_sync_r[2];
  assign cs_fall_s  = ~cs_sync_r[1] & cs_sync_r[2];
  assign lvl_s      = (WORD_W-2)'(count_r);

  // Status shifter: snapshot on select, then shift out MSB first on each sck fall.
  always_comb begin
    if (cs_fall_s) begin
      tx_nxt_s = {overflow_r, (state_r == DRAIN), lvl_s};
    end else if (cs_low_s && sck_fall_s) begin
      tx_nxt_s = {tx_r[WORD_W-2:0], 1'b0};
    end else begin
      tx_nxt_s = tx_r;
    end
  end

  // Registered miso, held low while deselected.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_r   <= {WORD_W{1'b0}};
      miso_r <= 1'b0;
    end else begin
      tx_r   <= tx_nxt_s;
      miso_r <= cs_low_s ? tx_nxt_s[WORD_W-1] : 1'b0;
    end
  end

  assign miso = miso_r;
`else
  assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_stream_buffer.sv
// Directed self-checking bench for spi_stream_buffer using three instances:
// A: defaults; B: HIGH_WM=8/LOW_WM=4; C: DEPTH=8, HIGH_WM=5, DIV_W=10 (overflow/status).
module tb_spi_stream_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sck, mosi;
  logic a_cs_n, b_cs_n, c_cs_n;
  logic a_miso, b_miso, c_miso;
  logic [15:0] a_out_div, b_out_div;
  logic [9:0]  c_out_div;
  logic [7:0]  a_out_data, b_out_data, c_out_data;
  logic        a_out_strobe, b_out_strobe, c_out_strobe;
  logic [4:0]  a_fill, b_fill;
  logic [3:0]  c_fill;
  logic        a_draining, b_draining, c_draining;
  logic        a_overflow, b_overflow, c_overflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] a_dq[$];
  int         a_tq[$];
  logic [7:0] b_dq[$];
  logic [7:0] c_dq[$];

  spi_stream_buffer #(.WORD_W(8), .DEPTH(16), .HIGH_WM(16), .LOW_WM(0), .DIV_W(16)) u_a (
    .clk(clk), .rst(rst), .sck(sck), .cs_n(a_cs_n), .mosi(mosi), .miso(a_miso),
    .out_div(a_out_div), .out_data(a_out_data), .out_strobe(a_out_strobe),
    .fill_level(a_fill), .draining(a_draining), .overflow(a_overflow));

  spi_stream_buffer #(.WORD_W(8), .DEPTH(16), .HIGH_WM(8), .LOW_WM(4), .DIV_W(16)) u_b (
    .clk(clk), .rst(rst), .sck(sck), .cs_n(b_cs_n), .mosi(mosi), .miso(b_miso),
    .out_div(b_out_div), .out_data(b_out_data), .out_strobe(b_out_strobe),
    .fill_level(b_fill), .draining(b_draining), .overflow(b_overflow));

  spi_stream_buffer #(.WORD_W(8), .DEPTH(8), .HIGH_WM(5), .LOW_WM(0), .DIV_W(10)) u_c (
    .clk(clk), .rst(rst), .sck(sck), .cs_n(c_cs_n), .mosi(mosi), .miso(c_miso),
    .out_div(c_out_div), .out_data(c_out_data), .out_strobe(c_out_strobe),
    .fill_level(c_fill), .draining(c_draining), .overflow(c_overflow));

  // Cycle counter used to timestamp strobes.
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (a_out_strobe) begin a_dq.push_back(a_out_data); a_tq.push_back(cyc); end
    if (b_out_strobe) b_dq.push_back(b_out_data);
    if (c_out_strobe) c_dq.push_back(c_out_data);
  end

  function automatic logic [7:0] pat(int i);
    return 8'(i * 37 + 5);
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cs(int which, logic v);
    case (which)
      0: a_cs_n = v;
      1: b_cs_n = v;
      default: c_cs_n = v;
    endcase
  endtask

  task automatic shift_bits(logic [7:0] b, int nbits, int h);
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i];
      tick(h); sck = 1'b1;
      tick(h); sck = 1'b0;
    end
  endtask

  task automatic send_byte(int which, logic [7:0] b);
    set_cs(which, 1'b0); tick(4);
    shift_bits(b, 8, 2);
    tick(4); set_cs(which, 1'b1); tick(4);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(3); rst = 1'b0; tick(1);
    a_dq.delete(); a_tq.delete(); b_dq.delete(); c_dq.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({a_out_data, a_out_strobe, a_fill, a_draining, a_overflow, a_miso} !== 17'd0) begin
      errors++; $display("FAIL reset_a: got %h expected 0", {a_out_data, a_out_strobe, a_fill, a_draining, a_overflow, a_miso}); end
    checks++; if ({b_out_data, b_fill, b_draining, b_overflow, b_miso} !== 16'd0) begin
      errors++; $display("FAIL reset_b: got %h expected 0", {b_out_data, b_fill, b_draining, b_overflow, b_miso}); end
    checks++; if ({c_out_data, c_fill, c_draining, c_overflow, c_miso} !== 15'd0) begin
      errors++; $display("FAIL reset_c: got %h expected 0", {c_out_data, c_fill, c_draining, c_overflow, c_miso}); end
  endtask

  task automatic test_drain_order();
    logic [7:0] exp;
    do_reset();
    for (int i = 1; i <= 15; i++) send_byte(0, 8'(i));
    checks++; if (a_draining !== 1'b0) begin errors++; $display("FAIL drain_early: got %b expected 0", a_draining); end
    checks++; if (a_fill !== 5'd15) begin errors++; $display("FAIL fill15: got %0d expected 15", a_fill); end
    send_byte(0, 8'h10);
    checks++; if (a_draining !== 1'b1) begin errors++; $display("FAIL drain_start: got %b expected 1", a_draining); end
    for (int k = 0; k < 300 && a_dq.size() < 16; k++) tick(1);
    tick(5);
    checks++; if (a_dq.size() != 16) begin errors++; $display("FAIL drain_count: got %0d expected 16", a_dq.size()); end
    for (int i = 0; i < 16 && i < a_dq.size(); i++) begin
      exp = 8'(i + 1);
      checks++; if (a_dq[i] !== exp) begin errors++; $display("FAIL drain_data[%0d]: got %h expected %h", i, a_dq[i], exp); end
      if (i > 0) begin
        checks++; if (a_tq[i] - a_tq[i-1] != 4) begin errors++; $display("FAIL drain_space[%0d]: got %0d expected 4", i, a_tq[i] - a_tq[i-1]); end
      end
    end
    checks++; if ({a_draining, a_fill, a_overflow, a_out_strobe} !== 8'd0) begin
      errors++; $display("FAIL drain_end: got %h expected 0", {a_draining, a_fill, a_overflow, a_out_strobe}); end
    checks++; if (a_out_data !== 8'h10) begin errors++; $display("FAIL drain_hold: got %h expected 10", a_out_data); end
  endtask

  task automatic test_overflow_status();
    logic [7:0] rd;
    logic [7:0] exp_st;
    c_out_div = 10'h3FF;
    do_reset();
    for (int i = 0; i < 9; i++) send_byte(2, 8'(8'h11 + i));
    checks++; if (c_fill !== 4'd8) begin errors++; $display("FAIL ovf_fill: got %0d expected 8", c_fill); end
    checks++; if (c_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", c_overflow); end
    checks++; if (c_draining !== 1'b1) begin errors++; $display("FAIL ovf_drain: got %b expected 1", c_draining); end
    checks++; if (c_dq.size() != 0) begin errors++; $display("FAIL ovf_early_pop: got %0d expected 0", c_dq.size()); end
    for (int k = 0; k < 3500 && c_dq.size() < 3; k++) tick(1);
    tick(2);
    checks++; if (c_dq.size() != 3) begin errors++; $display("FAIL ovf_pops: got %0d expected 3", c_dq.size()); end
    if (c_dq.size() > 0) begin
      checks++; if (c_dq[0] !== 8'h11) begin errors++; $display("FAIL ovf_first: got %h expected 11", c_dq[0]); end
    end
    checks++; if (c_fill !== 4'd5) begin errors++; $display("FAIL st_fill: got %0d expected 5", c_fill); end
    // status readback, mode 0: sample before each rising edge, skip the 8th rise
    set_cs(2, 1'b0); mosi = 1'b0; tick(8);
    for (int i = 0; i < 8; i++) begin
      rd[7-i] = c_miso;
      if (i < 7) begin sck = 1'b1; tick(8); sck = 1'b0; tick(8); end
    end
    set_cs(2, 1'b1); tick(6);
`ifdef SPI_STATUS_EN
    exp_st = 8'hC5;
`else
    exp_st = 8'h00;
`endif
    checks++; if (rd !== exp_st) begin errors++; $display("FAIL status: got %h expected %h", rd, exp_st); end
    checks++; if (c_miso !== 1'b0) begin errors++; $display("FAIL miso_idle: got %b expected 0", c_miso); end
    checks++; if ({c_overflow, c_fill} !== 5'b1_0101) begin
      errors++; $display("FAIL ovf_sticky: got %b expected 10101", {c_overflow, c_fill}); end
  endtask

  task automatic test_back_to_back();
    a_out_div = 16'd31;
    do_reset();
    set_cs(0, 1'b0); tick(4);
    for (int i = 0; i < 16; i++) shift_bits(pat(i), 8, 2);
    for (int k = 0; k < 100 && a_dq.size() < 1; k++) tick(1);
    for (int i = 16; i < 66; i++) shift_bits(pat(i), 8, 2);
    checks++; if (a_fill < 5'd14) begin errors++; $display("FAIL b2b_level: got %0d expected >=14", a_fill); end
    tick(4); set_cs(0, 1'b1);
    for (int k = 0; k < 1500 && a_dq.size() < 66; k++) tick(1);
    tick(4);
    checks++; if (a_dq.size() != 66) begin errors++; $display("FAIL b2b_count: got %0d expected 66", a_dq.size()); end
    for (int i = 0; i < 66 && i < a_dq.size(); i++) begin
      checks++; if (a_dq[i] !== pat(i)) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, a_dq[i], pat(i)); end
    end
    checks++; if ({a_overflow, a_draining, a_fill} !== 7'd0) begin
      errors++; $display("FAIL b2b_end: got %h expected 0", {a_overflow, a_draining, a_fill}); end
  endtask

  task automatic test_partial_word();
    a_out_div = 16'd0;
    do_reset();
    set_cs(0, 1'b0); tick(4);
    shift_bits(8'hFF, 5, 2);
    tick(4); set_cs(0, 1'b1); tick(4);
    send_byte(0, 8'hA5);
    checks++; if (a_fill !== 5'd1) begin errors++; $display("FAIL partial_fill: got %0d expected 1", a_fill); end
    for (int i = 0; i < 15; i++) send_byte(0, 8'(8'h30 + i));
    for (int k = 0; k < 200 && a_dq.size() < 16; k++) tick(1);
    checks++; if (a_dq.size() != 16) begin errors++; $display("FAIL partial_count: got %0d expected 16", a_dq.size()); end
    if (a_dq.size() > 1) begin
      checks++; if (a_dq[0] !== 8'hA5) begin errors++; $display("FAIL partial_word0: got %h expected a5", a_dq[0]); end
      checks++; if (a_dq[1] !== 8'h30) begin errors++; $display("FAIL partial_word1: got %h expected 30", a_dq[1]); end
    end
  endtask

  task automatic test_watermark();
    b_out_div = 16'd1;
    do_reset();
    for (int i = 0; i < 7; i++) send_byte(1, 8'(8'h21 + i));
    checks++; if (b_draining !== 1'b0) begin errors++; $display("FAIL wm_early: got %b expected 0", b_draining); end
    send_byte(1, 8'h28);
    for (int k = 0; k < 100 && b_dq.size() < 4; k++) tick(1);
    tick(40);
    checks++; if (b_dq.size() != 4) begin errors++; $display("FAIL wm_pops: got %0d expected 4", b_dq.size()); end
    for (int i = 0; i < 4 && i < b_dq.size(); i++) begin
      checks++; if (b_dq[i] !== 8'(8'h21 + i)) begin errors++; $display("FAIL wm_data[%0d]: got %h expected %h", i, b_dq[i], 8'(8'h21 + i)); end
    end
    checks++; if ({b_draining, b_fill, b_out_strobe} !== 7'b0_00100_0) begin
      errors++; $display("FAIL wm_end: got %b expected 0001000", {b_draining, b_fill, b_out_strobe}); end
    checks++; if (b_out_data !== 8'h24) begin errors++; $display("FAIL wm_hold: got %h expected 24", b_out_data); end
  endtask

  initial begin
    rst = 1'b1; sck = 1'b0; mosi = 1'b0;
    a_cs_n = 1'b1; b_cs_n = 1'b1; c_cs_n = 1'b1;
    a_out_div = 16'd3; b_out_div = 16'd1; c_out_div = 10'h3FF;
    test_reset();
    test_drain_order();
    test_overflow_status();
    test_back_to_back();
    test_partial_word();
    test_watermark();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
